// File: rtl/me_search_ctrl.sv
//------------------------------------------------------------------------------
// me_search_ctrl : full-search motion estimation pass sequencer (TB load,
//                  raster window stream, PE drain) driving the address generator.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module me_search_ctrl #(
    parameter int SW_W    = 64,
    parameter int TB_W    = 16,
    parameter int ADDR_SW = 12,
    parameter int ADDR_TB = 8,
    parameter int DRAIN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mem_rdy,
    output logic                    clr,
    output logic                    en_tb,
    output logic                    en_sw,
    output logic [$clog2(SW_W)-1:0] sw_x,
    output logic [$clog2(SW_W)-1:0] sw_y,
    output logic                    cand_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int XW = $clog2(SW_W);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [XW-1:0]      C_X_LAST     = XW'(SW_W - 1);
    localparam logic [XW-1:0]      C_CAND_MIN   = XW'(TB_W - 1);
    localparam logic [ADDR_TB-1:0] C_TB_LAST    = ADDR_TB'(TB_W * TB_W - 1);
    localparam logic [DW-1:0]      C_DRAIN_LAST = DW'(DRAIN - 1);

    // Geometry must match the address generator's address widths exactly.
    if ((SW_W * SW_W != 2 ** ADDR_SW) || (TB_W * TB_W != 2 ** ADDR_TB) ||
        (TB_W > SW_W) || (DRAIN < 1)) begin : g_param_chk
        $error("me_search_ctrl: inconsistent geometry parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_LOAD_TB   = 3'd2,
        S_STREAM_SW = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_TB-1:0] tb_cnt_q, tb_cnt_d;
    logic [XW-1:0]      sw_x_q, sw_x_d;
    logic [XW-1:0]      sw_y_q, sw_y_d;
    logic [DW-1:0]      drain_cnt_q, drain_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tb_cnt_q    <= '0;
            sw_x_q      <= '0;
            sw_y_q      <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tb_cnt_q    <= tb_cnt_d;
            sw_x_q      <= sw_x_d;
            sw_y_q      <= sw_y_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tb_cnt_d    = tb_cnt_q;
        sw_x_d      = sw_x_q;
        sw_y_d      = sw_y_q;
        drain_cnt_d = drain_cnt_q;
        en_tb       = 1'b0;
        en_sw       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                tb_cnt_d    = '0;
                sw_x_d      = '0;
                sw_y_d      = '0;
                drain_cnt_d = '0;
                state_d     = S_LOAD_TB;
            end
            S_LOAD_TB: begin
                en_tb = mem_rdy;
                if (mem_rdy) begin
                    if (tb_cnt_q == C_TB_LAST) begin
                        tb_cnt_d = '0;
                        state_d  = S_STREAM_SW;
                    end else begin
                        tb_cnt_d = tb_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM_SW: begin
                en_sw = mem_rdy;
                if (mem_rdy) begin
                    if (sw_x_q == C_X_LAST) begin
                        sw_x_d = '0;
                        if (sw_y_q == C_X_LAST) begin
                            sw_y_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            sw_y_d = sw_y_q + 1'b1;
                        end
                    end else begin
                        sw_x_d = sw_x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == C_DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything; the beat already presented this cycle still counts.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            tb_cnt_d    = '0;
            sw_x_d      = '0;
            sw_y_d      = '0;
            drain_cnt_d = '0;
        end
    end

    assign clr        = (state_q == S_CLEAR);
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sw_x       = sw_x_q;
    assign sw_y       = sw_y_q;
    assign cand_valid = en_sw && (sw_x_q >= C_CAND_MIN) && (sw_y_q >= C_CAND_MIN);

endmodule

`default_nettype wire

// File: tb/tb_me_search_ctrl.sv
//------------------------------------------------------------------------------
// tb_me_search_ctrl : scoreboard bench for me_search_ctrl (8/4 geometry plus a
//                     default-geometry instance for the full candidate count).
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_me_search_ctrl;

    localparam int SW_W = 8;
    localparam int TB_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mem_rdy = 1'b1;
    logic       clr, en_tb, en_sw, cand_valid, busy, done;
    logic [2:0] sw_x, sw_y;

    logic       d_start = 1'b0;
    logic       d_clr, d_en_tb, d_en_sw, d_cand_valid, d_busy, d_done;
    logic [5:0] d_sw_x, d_sw_y;

    me_search_ctrl #(
        .SW_W(SW_W), .TB_W(TB_W), .ADDR_SW(6), .ADDR_TB(4), .DRAIN(4)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_rdy(mem_rdy),
        .clr(clr), .en_tb(en_tb), .en_sw(en_sw), .sw_x(sw_x), .sw_y(sw_y),
        .cand_valid(cand_valid), .busy(busy), .done(done)
    );

    me_search_ctrl u_dut_def (
        .clk(clk), .rst(rst), .start(d_start), .abort(1'b0), .mem_rdy(1'b1),
        .clr(d_clr), .en_tb(d_en_tb), .en_sw(d_en_sw), .sw_x(d_sw_x), .sw_y(d_sw_y),
        .cand_valid(d_cand_valid), .busy(d_busy), .done(d_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_sw;
        int x;
        int y;
        bit cand;
        int cyc;
    } beat_t;

    beat_t exp_q[$];
    int    clr_cycs[$];
    int    done_cycs[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    t0 = 0;
    bit    stall_mode = 1'b0;
    int    busy_cnt, cand_cnt, first_cand, last_cand, tb_beats, sw_beats;
    int    d_cand_cnt = 0, d_sw_cnt = 0, d_tb_cnt = 0, d_done_cnt = 0, d_clr_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        clr_cycs.delete();
        done_cycs.delete();
        busy_cnt   = 0;
        cand_cnt   = 0;
        first_cand = -1;
        last_cand  = -1;
        tb_beats   = 0;
        sw_beats   = 0;
    endtask

    // Expected beats of one uninterrupted pass whose start is sampled at rel cycle base.
    task automatic push_pass(input int base, input bit stall);
        beat_t b;
        for (int i = 0; i < TB_W * TB_W; i++) begin
            b.is_sw = 1'b0; b.x = 0; b.y = 0; b.cand = 1'b0;
            b.cyc   = stall ? base + 3 + 2 * i : base + 2 + i;
            exp_q.push_back(b);
        end
        for (int j = 0; j < SW_W * SW_W; j++) begin
            b.is_sw = 1'b1;
            b.x     = j % SW_W;
            b.y     = j / SW_W;
            b.cand  = (b.x >= TB_W - 1) && (b.y >= TB_W - 1);
            b.cyc   = stall ? base + 35 + 2 * j : base + 18 + j;
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // In stall mode the source is ready on odd cycles only, so the first load cycle stalls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_rdy = stall_mode ? (((cyc - t0) & 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int    rel;
            beat_t b;
            rel = cyc - t0;
            if (clr) clr_cycs.push_back(rel);
            if (done) done_cycs.push_back(rel);
            if (busy) busy_cnt++;
            if (cand_valid) begin
                cand_cnt++;
                if (first_cand < 0) first_cand = rel;
                last_cand = rel;
                if (!en_sw) chk("cand_without_beat", 1, 0);
            end
            if (en_tb) tb_beats++;
            if (en_sw) sw_beats++;
            if (en_tb || en_sw) begin
                chk("enable_needs_rdy", int'(mem_rdy), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", rel, -1);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_kind", int'(en_sw), int'(b.is_sw));
                    chk("beat_cycle", rel, b.cyc);
                    if (b.is_sw) begin
                        chk("sw_x", int'(sw_x), b.x);
                        chk("sw_y", int'(sw_y), b.y);
                        chk("cand_valid", int'(cand_valid), int'(b.cand));
                    end
                end
            end
            if (d_cand_valid) d_cand_cnt++;
            if (d_en_sw) d_sw_cnt++;
            if (d_en_tb) d_tb_cnt++;
            if (d_done) d_done_cnt++;
            if (d_clr) d_clr_cnt++;
        end
    end

    task automatic start_pass();
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_rel(input int target, input string tag);
        int n = 0;
        while ((cyc - t0) < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if ((cyc - t0) != target) chk({tag, "_wait_timeout"}, cyc - t0, target);
    endtask

    task automatic wait_done(input int count, input int limit, input string tag);
        int n = 0;
        while (done_cycs.size() < count && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (done_cycs.size() < count) chk({tag, "_done_timeout"}, done_cycs.size(), count);
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_pass(input string tag, input int done_at, input int busy_n,
                              input int c_first, input int c_last);
        chk({tag, "_clr_count"}, clr_cycs.size(), 1);
        if (clr_cycs.size() > 0) chk({tag, "_clr_cycle"}, clr_cycs[0], 1);
        chk({tag, "_done_count"}, done_cycs.size(), 1);
        if (done_cycs.size() > 0) chk({tag, "_done_cycle"}, done_cycs[0], done_at);
        chk({tag, "_busy_cycles"}, busy_cnt, busy_n);
        chk({tag, "_tb_beats"}, tb_beats, 16);
        chk({tag, "_sw_beats"}, sw_beats, 64);
        chk({tag, "_cand_count"}, cand_cnt, 25);
        chk({tag, "_cand_first"}, first_cand, c_first);
        chk({tag, "_cand_last"}, last_cand, c_last);
        chk({tag, "_beats_left"}, exp_q.size(), 0);
        chk({tag, "_idle_sw_xy"}, int'({sw_x, sw_y}), 0);
    endtask

    initial begin
        clear_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({clr, en_tb, en_sw, cand_valid, busy, done}), 0);
        chk("reset_sw_xy", int'({sw_x, sw_y}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal pass
        clear_mon();
        push_pass(0, 1'b0);
        start_pass();
        wait_done(1, 200, "nominal");
        check_pass("nominal", 86, 85, 45, 81);

        // Stalled pass: source ready every other cycle
        clear_mon();
        stall_mode = 1'b1;
        push_pass(0, 1'b1);
        start_pass();
        wait_done(1, 400, "stall");
        check_pass("stall", 166, 165, 89, 161);
        stall_mode = 1'b0;

        // Abort on the 10th window beat, then a clean pass
        clear_mon();
        push_pass(0, 1'b0);
        start_pass();
        wait_rel(27, "abort");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_en_sw", int'(en_sw), 0);
        chk("abort_sw_xy", int'({sw_x, sw_y}), 0);
        chk("abort_sw_beats", sw_beats, 10);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", done_cycs.size(), 0);
        clear_mon();
        push_pass(0, 1'b0);
        start_pass();
        wait_done(1, 200, "post_abort");
        check_pass("post_abort", 86, 85, 45, 81);

        // Start held high: back-to-back passes 87 cycles apart
        clear_mon();
        push_pass(0, 1'b0);
        push_pass(87, 1'b0);
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b1;
        wait_rel(100, "hold");
        start = 1'b0;
        wait_done(2, 300, "hold");
        chk("hold_clr_count", clr_cycs.size(), 2);
        if (clr_cycs.size() > 1) chk("hold_clr_second", clr_cycs[1], 88);
        chk("hold_done_count", done_cycs.size(), 2);
        if (done_cycs.size() > 1) begin
            chk("hold_done_first", done_cycs[0], 86);
            chk("hold_done_second", done_cycs[1], 173);
        end
        chk("hold_cand_count", cand_cnt, 50);
        chk("hold_beats_left", exp_q.size(), 0);

        // Asynchronous reset in the middle of the template load
        clear_mon();
        push_pass(0, 1'b0);
        start_pass();
        wait_rel(8, "areset");
        #2;
        chk("areset_pre_en_tb", int'(en_tb), 1);
        rst = 1'b1;
        #1;
        chk("areset_outputs", int'({clr, en_tb, en_sw, cand_valid, busy, done}), 0);
        chk("areset_sw_xy", int'({sw_x, sw_y}), 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("areset_idle_busy", int'(busy), 0);
        chk("areset_no_done", done_cycs.size(), 0);

        // Default 64/16 geometry: full candidate count
        @(posedge clk);
        #1;
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        for (int n = 0; n < 6000 && d_done_cnt == 0; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("def_done_count", d_done_cnt, 1);
        chk("def_clr_count", d_clr_cnt, 1);
        chk("def_tb_beats", d_tb_cnt, 256);
        chk("def_sw_beats", d_sw_cnt, 4096);
        chk("def_cand_count", d_cand_cnt, 2401);
        chk("def_idle", int'({d_busy, d_sw_x, d_sw_y}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
